// File: rtl/sram_ctrl.sv
// sram_ctrl: burst read/write controller for the single-port synchronous SRAM.
// Accepts read/write bursts over a valid/ready handshake. The SRAM port is fully
// registered, and read data comes back as a valid-qualified stream.
// Optional build macro SRAM_CTRL_RANGE_CHK_EN rejects start addresses >= DATA_DEPTH
// by pulsing err instead of starting a burst.
module sram_ctrl #(
   parameter int ADDR_DEPTH = 4,
   parameter int DATA_WIDTH = 8,
   parameter int DATA_DEPTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_wr,
   input  logic [ADDR_DEPTH-1:0] req_addr,
   input  logic [ADDR_DEPTH-1:0] req_len,
   input  logic                  wdata_valid,
   output logic                  wdata_ready,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic                  rdata_valid,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  rdata_last,
   output logic                  done,
   output logic                  busy,
   output logic                  err,
   output logic                  sram_cs_n,
   output logic                  sram_w_en,
   output logic                  sram_r_en,
   output logic [ADDR_DEPTH-1:0] sram_addr,
   output logic [DATA_WIDTH-1:0] sram_din,
   input  logic [DATA_WIDTH-1:0] sram_dout
);

   typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

   state_t                state_q, state_d;
   logic [ADDR_DEPTH-1:0] addr_q, addr_d;
   logic [ADDR_DEPTH-1:0] cnt_q, cnt_d;
   logic                  sram_cs_n_q, sram_cs_n_d;
   logic                  sram_w_en_q, sram_w_en_d;
   logic                  sram_r_en_q, sram_r_en_d;
   logic [ADDR_DEPTH-1:0] sram_addr_q, sram_addr_d;
   logic [DATA_WIDTH-1:0] sram_din_q, sram_din_d;
   // [0]: read on the SRAM port this cycle, [1]: its data is on sram_dout
   logic [1:0]            rd_vld_q, rd_vld_d;
   logic [1:0]            rd_last_q, rd_last_d;
   logic                  rdata_valid_q, rdata_valid_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  rdata_last_q, rdata_last_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic                  req_fire;
   logic                  req_bad;

   // Wrapping word-address increment over the populated part of the SRAM
   function automatic logic [ADDR_DEPTH-1:0] next_addr(input logic [ADDR_DEPTH-1:0] a);
      return (a == ADDR_DEPTH'(DATA_DEPTH - 1)) ? '0 : a + 1'b1;
   endfunction

   assign req_fire = (state_q == IDLE) && req_valid;

`ifdef SRAM_CTRL_RANGE_CHK_EN
   assign req_bad = ({1'b0, req_addr} >= (ADDR_DEPTH + 1)'(DATA_DEPTH));
`else
   assign req_bad = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; a single-beat read goes straight to DRAIN because its
   // only issue happens on the acceptance edge
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_fire && !req_bad)
                     state_d = req_wr ? WRITE : ((req_len == '0) ? DRAIN : READ);
         WRITE:   if (wdata_valid && (cnt_q == '0)) state_d = IDLE;
         READ:    if (cnt_q == ADDR_DEPTH'(1)) state_d = DRAIN;
         DRAIN:   if (!rd_vld_q[0]) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake and status outputs decoded from state
   always_comb begin
      req_ready   = (state_q == IDLE);
      wdata_ready = (state_q == WRITE);
      busy        = (state_q != IDLE) || (rd_vld_q != '0);
   end

   // Datapath next values: the SRAM command, the burst address/counter and the read return pipe.
   // The first read is issued on the acceptance edge, so data returns two edges later.
   always_comb begin
      addr_d        = addr_q;
      cnt_d         = cnt_q;
      sram_cs_n_d   = 1'b1;
      sram_w_en_d   = 1'b0;
      sram_r_en_d   = 1'b0;
      sram_addr_d   = sram_addr_q;
      sram_din_d    = sram_din_q;
      rd_vld_d      = {rd_vld_q[0], 1'b0};
      rd_last_d     = {rd_last_q[0], 1'b0};
      rdata_valid_d = rd_vld_q[1];
      rdata_d       = rd_vld_q[1] ? sram_dout : rdata_q;
      rdata_last_d  = rd_vld_q[1] & rd_last_q[1];
      done_d        = rd_vld_q[1] & rd_last_q[1];
      err_d         = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_fire) begin
               if (req_bad) begin
                  err_d = 1'b1;
               end else begin
                  addr_d = req_addr;
                  cnt_d  = req_len;
                  if (!req_wr) begin
                     sram_cs_n_d  = 1'b0;
                     sram_r_en_d  = 1'b1;
                     sram_addr_d  = req_addr;
                     addr_d       = next_addr(req_addr);
                     rd_vld_d[0]  = 1'b1;
                     rd_last_d[0] = (req_len == '0);
                  end
               end
            end
         end
         WRITE: begin
            if (wdata_valid) begin
               sram_cs_n_d = 1'b0;
               sram_w_en_d = 1'b1;
               sram_addr_d = addr_q;
               sram_din_d  = wdata;
               addr_d      = next_addr(addr_q);
               if (cnt_q == '0) done_d = 1'b1;
               else             cnt_d  = cnt_q - 1'b1;
            end
         end
         READ: begin
            sram_cs_n_d  = 1'b0;
            sram_r_en_d  = 1'b1;
            sram_addr_d  = addr_q;
            addr_d       = next_addr(addr_q);
            cnt_d        = cnt_q - 1'b1;
            rd_vld_d[0]  = 1'b1;
            rd_last_d[0] = (cnt_q == ADDR_DEPTH'(1));
         end
         default: ;
      endcase
   end

   // Datapath registers; reset drops any in-flight read data
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q        <= '0;
         cnt_q         <= '0;
         sram_cs_n_q   <= 1'b1;
         sram_w_en_q   <= 1'b0;
         sram_r_en_q   <= 1'b0;
         sram_addr_q   <= '0;
         sram_din_q    <= '0;
         rd_vld_q      <= '0;
         rd_last_q     <= '0;
         rdata_valid_q <= 1'b0;
         rdata_q       <= '0;
         rdata_last_q  <= 1'b0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         addr_q        <= addr_d;
         cnt_q         <= cnt_d;
         sram_cs_n_q   <= sram_cs_n_d;
         sram_w_en_q   <= sram_w_en_d;
         sram_r_en_q   <= sram_r_en_d;
         sram_addr_q   <= sram_addr_d;
         sram_din_q    <= sram_din_d;
         rd_vld_q      <= rd_vld_d;
         rd_last_q     <= rd_last_d;
         rdata_valid_q <= rdata_valid_d;
         rdata_q       <= rdata_d;
         rdata_last_q  <= rdata_last_d;
         done_q        <= done_d;
         err_q         <= err_d;
      end
   end

   assign sram_cs_n   = sram_cs_n_q;
   assign sram_w_en   = sram_w_en_q;
   assign sram_r_en   = sram_r_en_q;
   assign sram_addr   = sram_addr_q;
   assign sram_din    = sram_din_q;
   assign rdata_valid = rdata_valid_q;
   assign rdata       = rdata_q;
   assign rdata_last  = rdata_last_q;
   assign done        = done_q;
   assign err         = err_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: testbench for sram_ctrl with a behavioural SRAM and a memory reference model.
// It applies directed table vectors, the corner sequences and random bursts.
`timescale 1ns/1ps
module tb_sram_ctrl;
   localparam int AW = 4;
   localparam int DW = 8;
`ifdef SRAM_CTRL_RANGE_CHK_EN
   localparam int DEPTH = 12;
`else
   localparam int DEPTH = 16;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid, req_ready, req_wr;
   logic [AW-1:0] req_addr, req_len;
   logic          wdata_valid, wdata_ready;
   logic [DW-1:0] wdata;
   logic          rdata_valid, rdata_last, done, busy, err;
   logic [DW-1:0] rdata;
   logic          sram_cs_n, sram_w_en, sram_r_en;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_din, sram_dout;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sram_ctrl #(.ADDR_DEPTH(AW), .DATA_WIDTH(DW), .DATA_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_len(req_len),
      .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
      .rdata_valid(rdata_valid), .rdata(rdata), .rdata_last(rdata_last),
      .done(done), .busy(busy), .err(err),
      .sram_cs_n(sram_cs_n), .sram_w_en(sram_w_en), .sram_r_en(sram_r_en),
      .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
   );

   // Behavioural SRAM: one-cycle registered read; mem_clr zeroes it at start
   logic          mem_clr;
   logic [DW-1:0] mem [16];
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 16; i++) mem[i] <= '0;
      end else if (!sram_cs_n) begin
         if (sram_w_en) mem[sram_addr] <= sram_din;
         if (sram_r_en) sram_dout <= mem[sram_addr];
      end
   end

   // Reference model: word contents plus the ordered list of SRAM writes each burst must produce
   logic [DW-1:0]    ref_mem [DEPTH];
   logic [AW+DW-1:0] exp_wr [$];
   logic [AW+DW-1:0] mon_e;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Every SRAM write is compared against the next expected one
   always @(posedge clk) begin
      if (!rst && !mem_clr && !sram_cs_n && sram_w_en) begin
         if (exp_wr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected no write", sram_addr, sram_din);
         end else begin
            mon_e = exp_wr.pop_front();
            chk("write_port", {sram_addr, sram_din}, mon_e);
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_ready;
      int n = 0;
      while (!req_ready && n < 50) begin
         tick();
         n++;
      end
      chk("req_ready_wait", req_ready, 1);
   endtask

   task automatic do_write(input int addr, input int len, input logic [15:0][DW-1:0] data,
                           input logic [15:0] gaps);
      wait_ready();
      req_valid = 1'b1; req_wr = 1'b1; req_addr = AW'(addr); req_len = AW'(len);
      for (int k = 0; k <= len; k++) begin
         exp_wr.push_back({AW'((addr + k) % DEPTH), data[k]});
         ref_mem[(addr + k) % DEPTH] = data[k];
      end
      tick();
      req_valid = 1'b0;
      chk("wr_wdata_ready", wdata_ready, 1);
      chk("wr_req_ready", req_ready, 0);
      chk("wr_err", err, 0);
      for (int k = 0; k <= len; k++) begin
         if (gaps[k]) begin
            // idle beat; a stray request here must be ignored
            wdata_valid = 1'b0; wdata = DW'($urandom); req_valid = 1'b1; req_wr = 1'b0;
            tick();
            req_valid = 1'b0;
            chk("wr_gap_no_write", sram_w_en, 0);
            chk("wr_gap_done", done, 0);
         end
         wdata_valid = 1'b1; wdata = data[k];
         tick();
         wdata_valid = 1'b0;
         chk("wr_done", done, (k == len));
      end
      chk("wr_idle_after", req_ready, 1);
   endtask

   task automatic do_read(input int addr, input int len, input logic use_tbl,
                          input logic [15:0][DW-1:0] tbl_exp);
      logic [15:0][DW-1:0] e;
      wait_ready();
      for (int k = 0; k <= len; k++) e[k] = use_tbl ? tbl_exp[k] : ref_mem[(addr + k) % DEPTH];
      req_valid = 1'b1; req_wr = 1'b0; req_addr = AW'(addr); req_len = AW'(len);
      wdata_valid = 1'($urandom_range(0, 1)); wdata = DW'($urandom);
      tick();
      req_valid = 1'b0;
      chk("rd_lat1_valid", rdata_valid, 0);
      chk("rd_busy", busy, 1);
      chk("rd_err", err, 0);
      tick();
      chk("rd_lat2_valid", rdata_valid, 0);
      for (int k = 0; k <= len; k++) begin
         tick();
         chk("rd_valid", rdata_valid, 1);
         chk("rd_data", rdata, e[k]);
         chk("rd_last", rdata_last, (k == len));
         chk("rd_done", done, (k == len));
      end
      wdata_valid = 1'b0;
      tick();
      chk("rd_end_valid", rdata_valid, 0);
      chk("rd_end_done", done, 0);
   endtask

   typedef struct {
      logic            wr;
      int              addr;
      int              len;
      logic [3:0]      gaps;
      logic [3:0][7:0] dat;   // write data, or expected read data
   } vec_t;
   vec_t tbl [6];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach its end, expected completion");
      $fatal(1);
   end

   initial begin
      logic [15:0][DW-1:0] d16;
      logic [15:0]         g16;
      int                  a, l;

      tbl[0] = '{wr: 1'b1, addr: 3,         len: 0, gaps: 4'b0000, dat: 32'h0000_00A5};
      tbl[1] = '{wr: 1'b0, addr: 3,         len: 0, gaps: 4'b0000, dat: 32'h0000_00A5};
      tbl[2] = '{wr: 1'b1, addr: DEPTH - 2, len: 3, gaps: 4'b0100, dat: 32'h4433_2211};
      tbl[3] = '{wr: 1'b0, addr: DEPTH - 2, len: 3, gaps: 4'b0000, dat: 32'h4433_2211};
      tbl[4] = '{wr: 1'b1, addr: 5,         len: 0, gaps: 4'b0000, dat: 32'h0000_005A};
      tbl[5] = '{wr: 1'b0, addr: 5,         len: 0, gaps: 4'b0000, dat: 32'h0000_005A};
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

      rst = 1'b1; mem_clr = 1'b1;
      req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_len = '0;
      wdata_valid = 1'b0; wdata = '0;
      @(negedge clk);
      tick();
      tick();
      chk("rst_cs_n", sram_cs_n, 1);
      chk("rst_w_en", sram_w_en, 0);
      chk("rst_r_en", sram_r_en, 0);
      chk("rst_addr", sram_addr, 0);
      chk("rst_din", sram_din, 0);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_wdata_ready", wdata_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rvalid", rdata_valid, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      rst = 1'b0; mem_clr = 1'b0;
      tick();

      // Table vectors; each read follows its write back-to-back in the first idle cycle
      for (int i = 0; i < 6; i++) begin
         d16 = '0;
         for (int j = 0; j < 4; j++) d16[j] = tbl[i].dat[j];
         g16 = {12'b0, tbl[i].gaps};
         if (tbl[i].wr) do_write(tbl[i].addr, tbl[i].len, d16, g16);
         else           do_read(tbl[i].addr, tbl[i].len, 1'b1, d16);
      end

      // Reset while idle must clear the held SRAM address/data registers
      tick();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("idle_rst_addr", sram_addr, 0);
      chk("idle_rst_din", sram_din, 0);
      chk("idle_rst_cs_n", sram_cs_n, 1);
      tick();

      // Reset during the 3rd beat of an 8-beat read aborts it without done
      wait_ready();
      req_valid = 1'b1; req_wr = 1'b0; req_addr = '0; req_len = AW'(7);
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      tick();
      tick();
      chk("abort_3rd_valid", rdata_valid, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_valid", rdata_valid, 0);
      chk("abort_req_ready", req_ready, 1);
      chk("abort_busy", busy, 0);
      chk("abort_r_en", sram_r_en, 0);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("abort_tail_valid", rdata_valid, 0);
         chk("abort_tail_done", done, 0);
      end

`ifdef SRAM_CTRL_RANGE_CHK_EN
      // Out-of-range start address: err pulse only, no access, no done
      for (int w = 0; w < 2; w++) begin
         wait_ready();
         req_valid = 1'b1; req_wr = 1'(w); req_addr = AW'(13); req_len = AW'(2);
         wdata_valid = 1'b1; wdata = 8'hEE;
         tick();
         req_valid = 1'b0;
         chk("range_err", err, 1);
         chk("range_cs_n", sram_cs_n, 1);
         chk("range_done", done, 0);
         chk("range_req_ready", req_ready, 1);
         tick();
         wdata_valid = 1'b0;
         chk("range_err_pulse", err, 0);
         chk("range_cs_n2", sram_cs_n, 1);
         chk("range_done2", done, 0);
      end
`else
      d16 = '0;
      do_read(13, 0, 1'b0, d16);
`endif

      // Random bursts checked against the reference model
      for (int i = 0; i < 40; i++) begin
         a = $urandom_range(0, DEPTH - 1);
         l = $urandom_range(0, 15);
         for (int j = 0; j < 16; j++) d16[j] = DW'($urandom);
         g16 = 16'($urandom) & 16'($urandom);
         if ($urandom_range(0, 1) == 1) do_write(a, l, d16, g16);
         else                           do_read(a, l, 1'b0, d16);
      end

      tick();
      chk("exp_writes_drained", exp_wr.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Initiator-side controller for the team's single-port synchronous SRAM macro (cs_n/w_en/r_en/addr/din/dout interface, one-cycle registered read data).
- Accepts burst read/write requests over a valid/ready handshake and streams write data in.
- Drives the SRAM port with registered signals and returns read data as a valid-qualified stream.
- Sits between a client datapath and the SRAM instance.

Parameters:
- ADDR_DEPTH, 4, address width in bits (SRAM addr width).
- DATA_WIDTH, 8, data word width.
- DATA_DEPTH, 16, number of SRAM words; must be <= 2**ADDR_DEPTH.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  high only in IDLE.
- req_wr  in  1  1 = write burst, 0 = read burst.
- req_addr  in  ADDR_DEPTH  start word address.
- req_len  in  ADDR_DEPTH  beats minus 1 (0 = one beat).
- wdata_valid  in  1  write beat valid.
- wdata_ready  out  1  high only in WRITE.
- wdata  in  DATA_WIDTH  write beat data.
- rdata_valid  out  1  read beat valid; no backpressure.
- rdata  out  DATA_WIDTH  read beat data.
- rdata_last  out  1  with final read beat.
- done  out  1  one-cycle pulse when a burst completes.
- busy  out  1  high whenever not IDLE or read pipe non-empty.
- err  out  1  one-cycle pulse on rejected request (see Optional Feature).
- sram_cs_n  out  1  to SRAM cs_n.
- sram_w_en  out  1  to SRAM w_en.
- sram_r_en  out  1  to SRAM r_en.
- sram_addr  out  ADDR_DEPTH  to SRAM addr.
- sram_din  out  DATA_WIDTH  to SRAM din.
- sram_dout  in  DATA_WIDTH  from SRAM dout.

Behaviour:
- One clock, clk; reset rst is synchronous and active-high.
- Reset values (rst sampled high at an edge):
  - State IDLE.
  - sram_cs_n=1; sram_w_en, sram_r_en, sram_addr, sram_din = 0.
  - rdata_valid, rdata, rdata_last, done, err, busy = 0.
  - req_ready=1, wdata_ready=0.
  - In-flight read data is discarded; a reset mid-burst aborts it with no done pulse.
- FSM states: IDLE, WRITE, READ, DRAIN. All SRAM-side outputs are registered.
- IDLE:
  - req_valid && req_ready latches addr, remaining-beat counter = req_len, and direction.
  - Moves to WRITE or READ.
  - SRAM outputs idle: cs_n=1, w_en=0, r_en=0.
- WRITE:
  - Each edge with wdata_valid=1 registers cs_n=0, w_en=1, addr=current, din=wdata; address then advances.
  - Cycles with wdata_valid=0 register cs_n=1, w_en=0; addr and counter hold.
  - On the last beat: go to IDLE and pulse done in the following cycle. The final write is still on the port that cycle, and the SRAM commits it at the next edge.
- READ:
  - Issues one read per cycle: cs_n=0, r_en=1, addr=current, for req_len+1 consecutive cycles.
  - A 2-stage valid pipe tracks in-flight reads. SRAM samples at edge T+1; the controller registers rdata=sram_dout, rdata_valid=1 at edge T+2.
  - After the last issue: r_en=0, cs_n=1, go to DRAIN.
- DRAIN:
  - Wait until the pipe is empty, then return to IDLE.
  - done pulses in the same cycle as the rdata_last beat.
- Latency:
  - Read: first rdata_valid is high in the 2nd cycle after the acceptance edge.
  - Read beats are contiguous, one per cycle.
  - Write: the SRAM commits beat k one edge after its handshake.
- Address wrap: next = (addr == DATA_DEPTH-1) ? 0 : addr+1. Bursts longer than DATA_DEPTH wrap and overwrite or re-read.
- Ordering: a read accepted in the IDLE cycle right after a write burst observes the written data. The write is sampled at the same edge the read command is registered.
- Ignored inputs:
  - req_valid outside IDLE (req_ready=0).
  - wdata_valid outside WRITE (wdata_ready=0).
- err is 0 unless the Optional Feature is compiled in.

Optional Feature:
- Macro: SRAM_CTRL_RANGE_CHK_EN.
- Defined: a request with req_addr >= DATA_DEPTH is accepted, gets no SRAM access, pulses err for one cycle in the next cycle, and stays in IDLE. No done pulse.
- Undefined: err tied 0; req_addr is used as-is.

Test Plan:
- rst high 2 cycles mid-idle -> sram_cs_n=1, req_ready=1, busy=0, rdata_valid=0, all SRAM outputs 0.
- Write addr 3, len 0, wdata 0xA5; then read addr 3, len 0 -> rdata=0xA5 with rdata_valid, rdata_last and done high, exactly 2 cycles after read acceptance.
- Write addr 14, len 3, data 0x11,0x22,0x33,0x44, with a one-cycle wdata_valid gap after beat 2 -> SRAM writes at 14,15,0,1; no write during the gap. Read back addr 14, len 3 -> 4 contiguous beats 0x11..0x44, rdata_last on the 4th.
- Write addr 5 = 0x5A, immediately followed by read addr 5 accepted in the first IDLE cycle -> rdata=0x5A.
- Read addr 0, len 7; assert rst on the 3rd rdata_valid cycle -> rdata_valid=0 from the next cycle on, no done, state IDLE, req_ready=1.
- With SRAM_CTRL_RANGE_CHK_EN, DATA_DEPTH=12: request addr 13 -> err pulse 1 cycle, sram_cs_n stays 1, no done. Without the macro, the err port stays 0.
